// File: rtl/instr_fetch.sv
// Instruction fetch stage: 1-cycle-latency instruction memory, in-order output buffer, redirect flush.
// Define IFETCH_ALIGN_CHECK_EN to trap misaligned redirects in a FAULT state flagged on fetch_fault.
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        fetch_fault
);
   localparam int unsigned PW = $clog2(BUF_DEPTH);

   typedef logic [PW:0]   cnt_t;
   typedef logic [PW-1:0] ptr_t;

`ifdef IFETCH_ALIGN_CHECK_EN
   typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
`else
   typedef enum logic {BOOT, RUN} state_t;
`endif

   state_t      state_q, state_d;
   logic [31:0] fpc_q;
   logic [31:0] tag_q;
   logic        inflight_q;
   logic [31:0] instr_buf [BUF_DEPTH];
   logic [31:0] pc_buf    [BUF_DEPTH];
   ptr_t        head_q, tail_q;
   cnt_t        count_q;
   cnt_t        occ;
   logic        pop, push, issue;

`ifdef IFETCH_ALIGN_CHECK_EN
   logic        bad_redirect;
   assign bad_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign fetch_fault  = (state_q == FAULT);
`else
   assign fetch_fault  = 1'b0;
`endif

   // Reset is muxed in combinationally so the boot address shows before the first reset edge.
   assign mem_addr  = HRESETn ? {2'b00, fpc_q[31:2]} : {2'b00, RESET_PC[31:2]};
   assign out_valid = (count_q != '0);
   assign out_instr = instr_buf[head_q];
   assign out_pc    = pc_buf[head_q];

   always_ff @(posedge HCLK) begin
      if (!HRESETn) state_q <= BOOT;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      pop     = out_valid && out_ready;
      push    = inflight_q && mem_ready && !redirect_valid;
      // Occupancy after this cycle's pop, counting the outstanding request as a reserved slot.
      occ     = count_q - cnt_t'(pop) + cnt_t'(inflight_q);
      issue   = (state_q == RUN) && mem_ready && !redirect_valid && (occ < cnt_t'(BUF_DEPTH));
      case (state_q)
         BOOT: if (mem_ready) state_d = RUN;
         RUN:  state_d = RUN;
`ifdef IFETCH_ALIGN_CHECK_EN
         FAULT: if (redirect_valid) state_d = RUN;
`endif
         default: state_d = BOOT;
      endcase
`ifdef IFETCH_ALIGN_CHECK_EN
      if (bad_redirect) state_d = FAULT;
`endif
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         fpc_q      <= RESET_PC;
         tag_q      <= '0;
         inflight_q <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
            instr_buf[i] <= '0;
            pc_buf[i]    <= '0;
         end
      end else if (redirect_valid) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         inflight_q <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
         if (!bad_redirect) fpc_q <= redirect_pc & ~32'd3;
`else
         fpc_q <= redirect_pc & ~32'd3;
`endif
      end else begin
         if (push) begin
            assert (count_q < cnt_t'(BUF_DEPTH));
            instr_buf[tail_q] <= mem_rdata;
            pc_buf[tail_q]    <= tag_q;
            tail_q            <= tail_q + ptr_t'(1);
         end
         if (pop) head_q <= head_q + ptr_t'(1);
         count_q <= count_q + cnt_t'(push) - cnt_t'(pop);
         if (issue) begin
            fpc_q      <= fpc_q + 32'd4;
            tag_q      <= fpc_q;
            inflight_q <= 1'b1;
         end else if (push) begin
            inflight_q <= 1'b0;
         end
      end
   end
endmodule
